// File: rtl/fp_div_seq.sv
// Sequential binary32 divider (radix-2 restoring), fp_Z = fp_X / fp_Y, all operand classes.
// Latency: done pulses 29 cycles after the start cycle (UNPACK 1, DIVIDE 26, ROUND 1, DONE 1).
// Backpressure: none; start is only taken in IDLE and ignored while busy or in DONE.
module fp_div_seq #(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    input  logic [2:0]  r_mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf,
    output logic        div_zero,
    output logic        nv
);

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND, S_DONE} state_t;

    typedef struct packed {
        logic ovrf;
        logic udrf;
        logic div_zero;
        logic nv;
    } flags_t;

    localparam logic [4:0] CNT_LAST = 5'(QBITS - 1);

    state_t             state, state_nxt;
    logic [31:0]        x_q, y_q;
    logic [2:0]         mode_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [24:0]        rem_q;
    logic [23:0]        my_q;
    logic [QBITS-1:0]   quo_q;
    logic [4:0]         cnt_q;
    logic               spec_vld_q;
    logic [31:0]        spec_z_q;
    flags_t             spec_flg_q;
    flags_t             flg_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nxt = S_UNPACK;
            S_UNPACK: begin busy = 1'b1; state_nxt = S_DIVIDE; end
            S_DIVIDE: begin
                busy = 1'b1;
                if (cnt_q == CNT_LAST) state_nxt = S_ROUND;
            end
            S_ROUND:  begin busy = 1'b1; state_nxt = S_DONE; end
            S_DONE:   begin done = 1'b1; state_nxt = S_IDLE; end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Operand classification and normal-path setup, evaluated in UNPACK.
    logic [7:0]        ex, ey;
    logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, res_sign, shift;
    logic [23:0]       mx, my;
    logic [24:0]       rem_init;
    logic signed [9:0] exp_init;
    logic              spec_vld;
    logic [31:0]       spec_z;
    flags_t            spec_flg;

    always_comb begin
        ex       = x_q[30:23];
        ey       = y_q[30:23];
        x_zero   = (ex == 8'h00);
        y_zero   = (ey == 8'h00);
        x_inf    = (ex == 8'hFF) && (x_q[22:0] == 23'd0);
        y_inf    = (ey == 8'hFF) && (y_q[22:0] == 23'd0);
        x_nan    = (ex == 8'hFF) && (x_q[22:0] != 23'd0);
        y_nan    = (ey == 8'hFF) && (y_q[22:0] != 23'd0);
        res_sign = x_q[31] ^ y_q[31];
        mx       = {1'b1, x_q[22:0]};
        my       = {1'b1, y_q[22:0]};
        shift    = (mx < my);
        rem_init = shift ? {mx, 1'b0} : {1'b0, mx};
        exp_init = $signed({2'b00, ex}) - $signed({2'b00, ey}) + 10'sd127
                   - (shift ? 10'sd1 : 10'sd0);
        spec_vld = 1'b1;
        spec_z   = 32'd0;
        spec_flg = '0;
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            spec_z      = 32'h7FC0_0000;
            spec_flg.nv = 1'b1;
        end else if (x_inf) begin
            spec_z = {res_sign, 8'hFF, 23'd0};
        end else if (y_zero) begin
            spec_z            = {res_sign, 8'hFF, 23'd0};
            spec_flg.div_zero = 1'b1;
        end else if (x_zero || y_inf) begin
            spec_z = {res_sign, 31'd0};
        end else begin
            spec_vld = 1'b0;
        end
    end

    // One restoring step; the remainder stays below 2*my so 25 bits suffice.
    logic        rem_ge;
    logic [24:0] rem_diff, rem_step;

    always_comb begin
        rem_ge   = (rem_q >= {1'b0, my_q});
        rem_diff = rem_q - {1'b0, my_q};
        rem_step = (rem_ge ? rem_diff : rem_q) << 1;
    end

    logic              g_bit, r_bit, s_bit, inc;
    logic [24:0]       sum;
    logic signed [9:0] exp_r, carry_ext;
    logic [22:0]       frac_r;
    logic [31:0]       z_fin;
    flags_t            flg_fin;

    always_comb begin
        g_bit = quo_q[1];
        r_bit = quo_q[0];
        s_bit = |rem_q;
        case (mode_q)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign_q & (g_bit | r_bit | s_bit);
            3'b011:  inc = ~sign_q & (g_bit | r_bit | s_bit);
            3'b100:  inc = g_bit;
            default: inc = g_bit & (r_bit | s_bit | quo_q[2]);
        endcase
        sum       = {1'b0, quo_q[QBITS-1:2]} + {24'd0, inc};
        carry_ext = {9'd0, sum[24]};
        exp_r     = exp_q + carry_ext;
        // Without a carry the hidden bit sits in sum[23]; with a carry the significand is exactly 1.0.
        frac_r    = sum[23] ? sum[22:0] : 23'd0;
        z_fin     = {sign_q, exp_r[7:0], frac_r};
        flg_fin   = '0;
        if (spec_vld_q) begin
            z_fin   = spec_z_q;
            flg_fin = spec_flg_q;
        end else if (exp_r >= 10'sd255) begin
            flg_fin.ovrf = 1'b1;
            case (mode_q)
                3'b001:  z_fin = {sign_q, 31'h7F7F_FFFF};
                3'b010:  z_fin = sign_q ? 32'hFF80_0000 : 32'h7F7F_FFFF;
                3'b011:  z_fin = sign_q ? 32'hFF7F_FFFF : 32'h7F80_0000;
                default: z_fin = {sign_q, 31'h7F80_0000};
            endcase
        end else if (exp_r <= 10'sd0) begin
            flg_fin.udrf = 1'b1;
            z_fin        = {sign_q, 31'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            mode_q     <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            rem_q      <= '0;
            my_q       <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            spec_vld_q <= 1'b0;
            spec_z_q   <= '0;
            spec_flg_q <= '0;
            fp_Z       <= '0;
            flg_q      <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    x_q    <= fp_X;
                    y_q    <= fp_Y;
                    mode_q <= r_mode;
                    fp_Z   <= '0;
                    flg_q  <= '0;
                end
                S_UNPACK: begin
                    sign_q     <= res_sign;
                    exp_q      <= exp_init;
                    rem_q      <= rem_init;
                    my_q       <= my;
                    quo_q      <= '0;
                    cnt_q      <= '0;
                    spec_vld_q <= spec_vld;
                    spec_z_q   <= spec_z;
                    spec_flg_q <= spec_flg;
                end
                S_DIVIDE: begin
                    rem_q <= rem_step;
                    quo_q <= {quo_q[QBITS-2:0], rem_ge};
                    cnt_q <= cnt_q + 5'd1;
                end
                S_ROUND: begin
                    fp_Z  <= z_fin;
                    flg_q <= flg_fin;
                end
                default: ;
            endcase
        end
    end

    assign ovrf     = flg_q.ovrf;
    assign udrf     = flg_q.udrf;
    assign div_zero = flg_q.div_zero;
    assign nv       = flg_q.nv;

endmodule
